fetch_queue: RTL and testbench

FETCH_QUEUE -- requirements
Module: fetch_queue

---
 rtl/fetch_queue_pkg.sv | 13 +
 rtl/fetch_queue_fq_ram.sv | 48 ++++
 rtl/fetch_queue.sv | 87 ++++++++
 tb/tb_fetch_queue.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/fetch_queue_pkg.sv
// Shared types and defaults for the instruction fetch queue.
// Holds the queue entry layout and the default depth/reset address.
package fetch_queue_pkg;

    localparam int          FQ_DEPTH    = 4;
    localparam logic [31:0] FQ_RESET_PC = 32'h0;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fq_entry_t;

endpackage

// File: rtl/fetch_queue_fq_ram.sv
// Circular DEPTH x 64 entry store for the fetch queue: storage, pointers, count.
// Flush clears pointers and count and overrides any push/pop in the same cycle.
module fq_ram
    import fetch_queue_pkg::*;
#(
    parameter int DEPTH = FQ_DEPTH
) (
    input  logic                       clock,
    input  logic                       clear,
    input  logic                       flush,
    input  logic                       push,
    input  logic                       pop,
    input  fq_entry_t                  wdata,
    output fq_entry_t                  head,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    fq_entry_t       mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;

    // DEPTH is a power of two, so pointer overflow is the modulo wrap.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clock) begin
        if (push && !flush) mem[wr_ptr] <= wdata;
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch queue: credit-based issue to a synchronous RAM, branch flush.
// Define FQ_BYPASS_EN to forward a returning word straight to id_* when the queue is empty.
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int          DEPTH    = FQ_DEPTH,
    parameter logic [31:0] RESET_PC = FQ_RESET_PC
) (
    input  logic        clock,
    input  logic        clear,
    input  logic        branch_taken,
    input  logic [31:0] branch_addr,
    input  logic        not_stall,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    output logic        id_valid,
    output logic [31:0] id_pc,
    output logic [31:0] id_instr
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [31:0]   fetch_pc;
    logic [31:0]   inflight_pc;
    logic          inflight;
    logic [CW-1:0] count;
    logic [CW:0]   used;
    logic          issue;
    logic          queued;
    logic          bypass;
    logic          push;
    logic          pop;
    fq_entry_t     head;
    fq_entry_t     ret_word;

    // Credit covers the word already in flight, so a push can never hit a full queue.
    assign used  = {1'b0, count} + {{CW{1'b0}}, inflight};
    assign issue = !branch_taken && (used < (CW+1)'(DEPTH));

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            fetch_pc    <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= 32'h0;
        end else if (branch_taken) begin
            fetch_pc <= branch_addr;
            inflight <= 1'b0;
        end else if (issue) begin
            inflight    <= 1'b1;
            inflight_pc <= fetch_pc;
            fetch_pc    <= fetch_pc + 32'd1;
        end else begin
            inflight <= 1'b0;
        end
    end

    assign imem_addr = fetch_pc;
    assign ret_word  = '{pc: inflight_pc, instr: imem_data};
    assign queued    = (count != '0);

`ifdef FQ_BYPASS_EN
    assign bypass = !queued && inflight;
`else
    assign bypass = 1'b0;
`endif

    // Decode handshake: the head transfers on a clock edge where id_valid and
    // not_stall are both high; id_* stay stable while not_stall is low.
    assign push = inflight && !branch_taken && !(bypass && not_stall);
    assign pop  = queued && not_stall && !branch_taken;

    assign id_valid = queued || bypass;
    assign id_pc    = queued ? head.pc    : (bypass ? inflight_pc : 32'h0);
    assign id_instr = queued ? head.instr : (bypass ? imem_data   : 32'h0);

    fq_ram #(.DEPTH(DEPTH)) u_ram (
        .clock (clock),
        .clear (clear),
        .flush (branch_taken),
        .push  (push),
        .pop   (pop),
        .wdata (ret_word),
        .head  (head),
        .count (count)
    );

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue with a synchronous instruction RAM model.
// Latency expectations follow FQ_BYPASS_EN when it is defined.
module tb_fetch_queue;

    logic        clock = 1'b0;
    logic        clear = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_addr = 32'h0;
    logic        not_stall = 1'b0;
    logic [31:0] imem_addr;
    logic [31:0] imem_data = 32'h0;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [31:0] id_instr;

    int total = 0;
    int bad   = 0;
    logic [31:0] exp_q[$];

`ifdef FQ_BYPASS_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 2;
`endif

    fetch_queue dut (
        .clock        (clock),
        .clear        (clear),
        .branch_taken (branch_taken),
        .branch_addr  (branch_addr),
        .not_stall    (not_stall),
        .imem_addr    (imem_addr),
        .imem_data    (imem_data),
        .id_valid     (id_valid),
        .id_pc        (id_pc),
        .id_instr     (id_instr)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] ram_word(input logic [31:0] a);
        case (a)
            32'd0:   ram_word = 32'h00100093;
            32'd1:   ram_word = 32'h00200113;
            32'd2:   ram_word = 32'h00209463;
            32'd3:   ram_word = 32'h00100193;
            default: ram_word = 32'hC000_0000 | (a & 32'h00FF_FFFF);
        endcase
    endfunction

    // Synchronous RAM: data for the address seen at an edge appears after it.
    always @(posedge clock) imem_data <= ram_word(imem_addr);

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        clear = 1'b0;
        branch_taken = 1'b0;
        not_stall = 1'b0;
        step();
        step();
        clear = 1'b1;
    endtask

    task automatic wait_valid(input int budget, output int edges, output bit found);
        edges = 0;
        found = id_valid;
        while (!found && edges < budget) begin
            step();
            edges++;
            found = id_valid;
        end
    endtask

    task automatic test_reset();
        clear = 1'b0;
        #2;
        total++; if (id_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b exp=0", id_valid); end
        total++; if (id_pc !== 32'h0) begin bad++; $display("FAIL rst_pc got=%h exp=0", id_pc); end
        total++; if (id_instr !== 32'h0) begin bad++; $display("FAIL rst_instr got=%h exp=0", id_instr); end
        total++; if (imem_addr !== 32'h0) begin bad++; $display("FAIL rst_addr got=%h exp=0", imem_addr); end
    endtask

    task automatic test_stream();
        int n;
        bit f;
        do_reset();
        not_stall = 1'b1;
        wait_valid(10, n, f);
        total++; if (!f || n != LAT) begin bad++; $display("FAIL stream_latency got=%0d exp=%0d found=%b", n, LAT, f); end
        for (int i = 0; i < 4; i++) begin
            total++;
            if (id_valid !== 1'b1 || id_pc !== 32'(i) || id_instr !== ram_word(32'(i))) begin
                bad++;
                $display("FAIL stream_%0d got v=%b pc=%h ins=%h exp pc=%h ins=%h", i, id_valid, id_pc, id_instr, 32'(i), ram_word(32'(i)));
            end
            step();
        end
    endtask

    task automatic test_stall();
        int n;
        bit f;
        logic [31:0] e;
        do_reset();
        not_stall = 1'b0;
        wait_valid(10, n, f);
        total++; if (!f) begin bad++; $display("FAIL stall_first got=timeout exp=valid"); end
        for (int i = 0; i < 10; i++) begin
            step();
            total++; if (id_valid !== 1'b1 || id_pc !== 32'h0) begin bad++; $display("FAIL stall_hold_%0d got v=%b pc=%h exp v=1 pc=0", i, id_valid, id_pc); end
        end
        total++; if (imem_addr !== 32'd4) begin bad++; $display("FAIL stall_addr got=%h exp=4", imem_addr); end
        exp_q = {32'd0, 32'd1, 32'd2, 32'd3, 32'd4};
        not_stall = 1'b1;
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            total++;
            if (id_valid !== 1'b1 || id_pc !== e || id_instr !== ram_word(e)) begin
                bad++;
                $display("FAIL drain got v=%b pc=%h ins=%h exp pc=%h ins=%h", id_valid, id_pc, id_instr, e, ram_word(e));
            end
            step();
        end
    endtask

    task automatic test_branch_full();
        int n;
        bit f;
        do_reset();
        not_stall = 1'b0;
        repeat (8) step();
        branch_taken = 1'b1;
        branch_addr = 32'h10;
        step();
        branch_taken = 1'b0;
        total++; if (id_valid !== 1'b0) begin bad++; $display("FAIL brfull_flush got=%b exp=0", id_valid); end
        not_stall = 1'b1;
        wait_valid(10, n, f);
        total++; if (!f || n != LAT) begin bad++; $display("FAIL brfull_latency got=%0d exp=%0d found=%b", n, LAT, f); end
        total++; if (id_pc !== 32'h10 || id_instr !== ram_word(32'h10)) begin bad++; $display("FAIL brfull_first got pc=%h ins=%h exp pc=10 ins=%h", id_pc, id_instr, ram_word(32'h10)); end
        step();
        total++; if (id_valid !== 1'b1 || id_pc !== 32'h11) begin bad++; $display("FAIL brfull_next got v=%b pc=%h exp v=1 pc=11", id_valid, id_pc); end
    endtask

    task automatic test_branch_pop_push();
        int n;
        bit f;
        do_reset();
        not_stall = 1'b1;
        wait_valid(10, n, f);
        branch_taken = 1'b1;
        branch_addr = 32'h20;
        step();
        branch_taken = 1'b0;
        total++; if (id_valid !== 1'b0) begin bad++; $display("FAIL brpp_flush got=%b exp=0", id_valid); end
        wait_valid(10, n, f);
        total++; if (!f || id_pc !== 32'h20) begin bad++; $display("FAIL brpp_first got pc=%h found=%b exp pc=20", id_pc, f); end
        step();
        total++; if (id_valid !== 1'b1 || id_pc !== 32'h21) begin bad++; $display("FAIL brpp_next got v=%b pc=%h exp v=1 pc=21", id_valid, id_pc); end
    endtask

    task automatic test_clear_mid();
        int n;
        bit f;
        do_reset();
        not_stall = 1'b1;
        wait_valid(10, n, f);
        step();
        step();
        clear = 1'b0;
        #1;
        total++;
        if (id_valid !== 1'b0 || id_pc !== 32'h0 || id_instr !== 32'h0 || imem_addr !== 32'h0) begin
            bad++;
            $display("FAIL clear_mid got v=%b pc=%h ins=%h addr=%h exp all 0", id_valid, id_pc, id_instr, imem_addr);
        end
        step();
        clear = 1'b1;
        wait_valid(10, n, f);
        total++; if (!f || n != LAT || id_pc !== 32'h0) begin bad++; $display("FAIL clear_restart got pc=%h lat=%0d exp pc=0 lat=%0d", id_pc, n, LAT); end
    endtask

    task automatic test_wrap();
        int n;
        bit f;
        not_stall = 1'b1;
        branch_taken = 1'b1;
        branch_addr = 32'hFFFF_FFFF;
        step();
        branch_taken = 1'b0;
        wait_valid(10, n, f);
        total++; if (!f || id_pc !== 32'hFFFF_FFFF || id_instr !== ram_word(32'hFFFF_FFFF)) begin bad++; $display("FAIL wrap_top got pc=%h ins=%h exp pc=ffffffff", id_pc, id_instr); end
        step();
        total++; if (id_valid !== 1'b1 || id_pc !== 32'h0 || id_instr !== 32'h00100093) begin bad++; $display("FAIL wrap_zero got v=%b pc=%h ins=%h exp pc=0 ins=00100093", id_valid, id_pc, id_instr); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_branch_full();
        test_branch_pop_push();
        test_clear_mid();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
